addsub_pipe: RTL and testbench

- Parametrised, pipelined add/subtract unit.
- Operands are processed in SLICE-bit chunks, one chunk per pipeline stage, with the carry/borrow registered between stages. This gives a short critical path at any WIDTH.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure.
- Produces result, carry/borrow out, signed overflow and zero flags. Used as the shared arithmetic datapath for wide-word subtract/compare in the DSD designs.

---
 rtl/addsub_pipe.sv | 147 ++++++++++++++
 tb/tb_addsub_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one SLICE-bit chunk resolved per stage, carry registered between stages.
// Unprocessed operand bits shift down each stage; the finished result, carry/borrow and flags leave the last stage.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = (SLICE > 0) ? (WIDTH / SLICE) : 1;

    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_check
        $error("addsub_pipe: WIDTH must be a non-zero multiple of SLICE");
    end

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = ~rst_n | advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int UW = WIDTH - (k + 1) * SLICE;

        logic                   v_i;
        logic                   op_i;
        logic                   cy_i;
        logic                   am_i;
        logic                   bm_i;
        logic [SLICE-1:0]       as_i;
        logic [SLICE-1:0]       bs_i;
        logic [SLICE:0]         sum;
        logic [(k+1)*SLICE-1:0] r_nx;
        logic                   v_q;
        logic [(k+1)*SLICE-1:0] r_q;

        // Subtract runs as a + ~b + ~c_in, so the carry chain carries "no borrow".
        assign sum = {1'b0, as_i} + {1'b0, (op_i ? bs_i : ~bs_i)} + {{SLICE{1'b0}}, cy_i};

        if (k == 0) begin : g_src
            assign v_i  = in_valid;
            assign op_i = op;
            assign cy_i = op ? c_in : ~c_in;
            assign am_i = a[WIDTH-1];
            assign bm_i = b[WIDTH-1];
            assign as_i = a[SLICE-1:0];
            assign bs_i = b[SLICE-1:0];
            assign r_nx = sum[SLICE-1:0];
        end else begin : g_src
            assign v_i  = g_stage[k-1].v_q;
            assign op_i = g_stage[k-1].g_rem.op_q;
            assign cy_i = g_stage[k-1].g_rem.cy_q;
            assign am_i = g_stage[k-1].g_rem.am_q;
            assign bm_i = g_stage[k-1].g_rem.bm_q;
            assign as_i = g_stage[k-1].g_rem.a_q[SLICE-1:0];
            assign bs_i = g_stage[k-1].g_rem.b_q[SLICE-1:0];
            assign r_nx = {sum[SLICE-1:0], g_stage[k-1].r_q};
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                r_q <= '0;
            end else if (advance) begin
                v_q <= v_i;
                r_q <= r_nx;
            end
        end

        if (UW > 0) begin : g_rem
            logic [UW-1:0] a_nx;
            logic [UW-1:0] b_nx;
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;
            logic          op_q;
            logic          cy_q;
            logic          am_q;
            logic          bm_q;

            if (k == 0) begin : g_nx
                assign a_nx = a[WIDTH-1:SLICE];
                assign b_nx = b[WIDTH-1:SLICE];
            end else begin : g_nx
                assign a_nx = g_stage[k-1].g_rem.a_q[WIDTH-k*SLICE-1:SLICE];
                assign b_nx = g_stage[k-1].g_rem.b_q[WIDTH-k*SLICE-1:SLICE];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    op_q <= 1'b0;
                    cy_q <= 1'b0;
                    am_q <= 1'b0;
                    bm_q <= 1'b0;
                end else if (advance) begin
                    a_q  <= a_nx;
                    b_q  <= b_nx;
                    op_q <= op_i;
                    cy_q <= sum[SLICE];
                    am_q <= am_i;
                    bm_q <= bm_i;
                end
            end
        end
    end

    logic             last_op;
    logic             last_cy;
    logic             last_am;
    logic             last_bm;
    logic [WIDTH-1:0] last_r;

    assign last_op   = g_stage[STAGES-1].op_i;
    assign last_cy   = g_stage[STAGES-1].sum[SLICE];
    assign last_am   = g_stage[STAGES-1].am_i;
    assign last_bm   = g_stage[STAGES-1].bm_i;
    assign last_r    = g_stage[STAGES-1].r_nx;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign result    = g_stage[STAGES-1].r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (advance) begin
            c_out <= last_op ? last_cy : ~last_cy;
            ovf   <= (last_op ? (last_am == last_bm) : (last_am != last_bm))
                     && (last_r[WIDTH-1] != last_am);
            zero  <= ~|last_r;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and randomised bench for addsub_pipe: main instance at SLICE=4, plus SLICE=16 and SLICE=1 instances.
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        sw_valid;
    logic        op;
    logic        c_in;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        in_ready, out_valid, c_out, ovf, zero;
    logic [15:0] result;
    logic        s16_ready, s16_valid, s16_c, s16_ovf, s16_zero;
    logic [15:0] s16_result;
    logic        s1_ready, s1_valid, s1_c, s1_ovf, s1_zero;
    logic [15:0] s1_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(16), .SLICE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    addsub_pipe #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s16_ready),
        .op(op), .a(a), .b(b), .c_in(c_in),
        .out_valid(s16_valid), .out_ready(1'b1), .result(s16_result),
        .c_out(s16_c), .ovf(s16_ovf), .zero(s16_zero)
    );

    addsub_pipe #(.WIDTH(16), .SLICE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_ready),
        .op(op), .a(a), .b(b), .c_in(c_in),
        .out_valid(s1_valid), .out_ready(1'b1), .result(s1_result),
        .c_out(s1_c), .ovf(s1_ovf), .zero(s1_zero)
    );

    // Reference packed as {c_out, ovf, zero, result}.
    function automatic logic [18:0] model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [16:0] s;
        logic        v;
        if (o) s = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        else   s = {1'b0, x} - {1'b0, y} - {16'd0, ci};
        v = o ? ((x[15] == y[15]) && (s[15] != x[15])) : ((x[15] != y[15]) && (s[15] != x[15]));
        return {s[16], v, (s[15:0] == 16'd0), s[15:0]};
    endfunction

    // Offers one op with out_ready high and returns the first valid output and its latency.
    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y, input logic ci,
                         output logic [18:0] got, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = {c_out, ovf, zero, result};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
        op = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0)   begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++; if (c_out !== 1'b0)     begin errors++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (zero !== 1'b0)      begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
        checks++; if (s16_valid !== 1'b0) begin errors++; $display("FAIL reset_s16_valid: got %b expected 0", s16_valid); end
        checks++; if (s1_valid !== 1'b0)  begin errors++; $display("FAIL reset_s1_valid: got %b expected 0", s1_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic        vo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] va [7] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb [7] = '{16'h0235, 16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0000, 16'h8000};
        logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] er [7] = '{16'h0FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
        logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [18:0] got;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            do_op(vo[i], va[i], vb[i], vc[i], got, lat);
            checks++; if (lat != 4)           begin errors++; $display("FAIL arith[%0d] latency: got %0d expected 4", i, lat); end
            checks++; if (got[15:0] !== er[i]) begin errors++; $display("FAIL arith[%0d] result: got %h expected %h", i, got[15:0], er[i]); end
            checks++; if (got[18] !== ec[i])   begin errors++; $display("FAIL arith[%0d] c_out: got %b expected %b", i, got[18], ec[i]); end
            checks++; if (got[17] !== eo[i])   begin errors++; $display("FAIL arith[%0d] ovf: got %b expected %b", i, got[17], eo[i]); end
            checks++; if (got[16] !== ez[i])   begin errors++; $display("FAIL arith[%0d] zero: got %b expected %b", i, got[16], ez[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vo [8];
        logic        vc [8];
        logic [18:0] q[$];
        logic [18:0] exp, got, held_val;
        logic        held = 1'b0;
        logic        exp_ready;
        int c = 0, sent = 0, recv = 0, extra = 0;
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom); vb[i] = 16'($urandom);
            vo[i] = 1'($urandom);  vc[i] = 1'($urandom);
        end
        while (recv < 8 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 7);
            if (sent < 8) begin
                op = vo[sent]; a = va[sent]; b = vb[sent]; c_in = vc[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ready = (c < 5) || (c > 7);
            got = {c_out, ovf, zero, result};
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL b2b in_ready cycle %0d: got %b expected %b", c, in_ready, exp_ready); end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || got !== held_val) begin
                    errors++; $display("FAIL b2b hold cycle %0d: got %b/%h expected 1/%h", c, out_valid, got, held_val);
                end
            end
            held     = out_valid && !out_ready;
            held_val = got;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b extra output cycle %0d: got %h expected none", c, got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL b2b result[%0d]: got %h expected %h", recv, got, exp); end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(op, a, b, c_in));
                sent++;
            end
            c++;
        end
        checks++; if (recv != 8 || sent != 8) begin errors++; $display("FAIL b2b count: got sent %0d recv %0d expected 8/8", sent, recv); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL b2b duplicate: got %0d extra outputs expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [18:0] got;
        int          lat;
        int          leaked = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 1'b1; a = 16'(16'h0100 * (i + 1)); b = 16'h0011; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid accept[%0d] in_ready: got %b expected 1", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid out_valid after reset: got %b expected 0", out_valid); end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL mid leaked outputs: got %0d expected 0", leaked); end
        do_op(1'b0, 16'h0010, 16'h0001, 1'b0, got, lat);
        checks++; if (lat != 4)           begin errors++; $display("FAIL mid latency: got %0d expected 4", lat); end
        checks++; if (got !== {3'b000, 16'h000F}) begin errors++; $display("FAIL mid result: got %h expected %h", got, {3'b000, 16'h000F}); end
    endtask

    task automatic test_sweep();
        logic [18:0] q16[$];
        logic [18:0] q1[$];
        logic [18:0] exp, got;
        int c = 0, sent = 0, first16 = -1, first1 = -1;
        out_ready = 1'b1;
        while ((sent < 1000 || q16.size() > 0 || q1.size() > 0) && c < 1100) begin
            @(negedge clk);
            if (sent < 1000) begin
                op = 1'($urandom); a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sw_valid = 1'b1;
            end else begin
                sw_valid = 1'b0;
            end
            #1;
            if (s16_valid) begin
                if (first16 < 0) first16 = c;
                got = {s16_c, s16_ovf, s16_zero, s16_result};
                checks++;
                if (q16.size() == 0) begin errors++; $display("FAIL sweep16 extra cycle %0d: got %h expected none", c, got); end
                else begin
                    exp = q16.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL sweep16 cycle %0d: got %h expected %h", c, got, exp); end
                end
            end
            if (s1_valid) begin
                if (first1 < 0) first1 = c;
                got = {s1_c, s1_ovf, s1_zero, s1_result};
                checks++;
                if (q1.size() == 0) begin errors++; $display("FAIL sweep1 extra cycle %0d: got %h expected none", c, got); end
                else begin
                    exp = q1.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL sweep1 cycle %0d: got %h expected %h", c, got, exp); end
                end
            end
            if (sw_valid) begin
                checks++;
                if (!(s16_ready && s1_ready)) begin errors++; $display("FAIL sweep ready cycle %0d: got %b%b expected 11", c, s16_ready, s1_ready); end
                q16.push_back(model(op, a, b, c_in));
                q1.push_back(model(op, a, b, c_in));
                sent++;
            end
            c++;
        end
        sw_valid = 1'b0;
        checks++; if (first16 != 1) begin errors++; $display("FAIL sweep16 latency: got %0d expected 1", first16); end
        checks++; if (first1 != 16) begin errors++; $display("FAIL sweep1 latency: got %0d expected 16", first1); end
        checks++;
        if (sent != 1000 || q16.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL sweep drain: got sent %0d left %0d/%0d expected 1000 0/0", sent, q16.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
